// File: rtl/multi_dataflow_tile_sched_pkg.sv
// Shared types for the two-level tile scheduler: widths, FSM states and the
// control/flag bundles that the top-level ports map onto.
package multi_dataflow_tile_sched_pkg;

  localparam int unsigned NbStreams = 4;
  localparam int unsigned AddrW     = 32;
  localparam int unsigned CntW      = 16;

  typedef logic [AddrW-1:0]  addr_t;
  typedef logic [CntW-1:0]   cnt_t;
  typedef logic [2*CntW-1:0] tidx_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} sched_state_t;

  typedef struct packed {
    logic                   start;
    cnt_t                   n_inner;
    cnt_t                   n_outer;
    addr_t [NbStreams-1:0]  stride_inner;
    addr_t [NbStreams-1:0]  stride_outer;
    logic                   next;
  } ctrl_sched_t;

  typedef struct packed {
    addr_t [NbStreams-1:0]  offs;
    logic                   valid;
    tidx_t                  tile_idx;
    logic                   busy;
    logic                   done;
  } flags_sched_t;

endpackage

// File: rtl/multi_dataflow_tile_sched_if.sv
// Tile handshake between the main FSM (master) and the scheduler (slave).
interface multi_dataflow_tile_sched_if;
  import multi_dataflow_tile_sched_pkg::*;

  logic                   start_i;
  cnt_t                   n_inner_i;
  cnt_t                   n_outer_i;
  addr_t [NbStreams-1:0]  stride_inner_i;
  addr_t [NbStreams-1:0]  stride_outer_i;
  logic                   next_i;
  addr_t [NbStreams-1:0]  offs_o;
  logic                   valid_o;
  tidx_t                  tile_idx_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output start_i, n_inner_i, n_outer_i, stride_inner_i, stride_outer_i, next_i,
    input  offs_o, valid_o, tile_idx_o, busy_o, done_o
  );

  modport slave (
    input  start_i, n_inner_i, n_outer_i, stride_inner_i, stride_outer_i, next_i,
    output offs_o, valid_o, tile_idx_o, busy_o, done_o
  );

endinterface

// File: rtl/multi_dataflow_tile_sched_offs_gen.sv
// One stream's offset generator: row_base tracks the start of the current
// outer row, offs the current tile; both step by the latched strides.
module multi_dataflow_tile_sched_offs_gen
  import multi_dataflow_tile_sched_pkg::*;
(
  input  logic  clk_i,
  input  logic  clear_i,
  input  logic  load_i,
  input  logic  inner_step_i,
  input  logic  outer_step_i,
  input  addr_t stride_inner_i,
  input  addr_t stride_outer_i,
  output addr_t offs_o
);

  addr_t row_base_q, row_base_d;
  addr_t offs_q, offs_d;

  // Next offsets: load zeroes, outer step restarts the row, inner step advances.
  always_comb begin
    row_base_d = row_base_q;
    offs_d     = offs_q;
    if (load_i) begin
      row_base_d = '0;
      offs_d     = '0;
    end else if (outer_step_i) begin
      row_base_d = row_base_q + stride_outer_i;
      offs_d     = row_base_q + stride_outer_i;
    end else if (inner_step_i) begin
      offs_d = offs_q + stride_inner_i;
    end
  end

  // Offset registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      row_base_q <= '0;
      offs_q     <= '0;
    end else begin
      row_base_q <= row_base_d;
      offs_q     <= offs_d;
    end
  end

  assign offs_o = offs_q;

endmodule

// File: rtl/multi_dataflow_tile_sched.sv
// Two-level tile scheduler: walks an outer x inner tiling loop and offers one
// per-stream offset set per tile, advancing on next_i.
module multi_dataflow_tile_sched
  import multi_dataflow_tile_sched_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  multi_dataflow_tile_sched_if.slave    sched_io
);

  ctrl_sched_t  ctrl;
  flags_sched_t flags;

  sched_state_t          state_q, state_d;
  cnt_t                  n_inner_q, n_inner_d, n_outer_q, n_outer_d;
  cnt_t                  i_in_q, i_in_d, i_out_q, i_out_d;
  tidx_t                 tile_idx_q, tile_idx_d;
  addr_t [NbStreams-1:0] stride_inner_q, stride_inner_d;
  addr_t [NbStreams-1:0] stride_outer_q, stride_outer_d;
  addr_t [NbStreams-1:0] offs;
  logic                  flush, load, inner_step, outer_step;
  logic                  last_in, last_out;

  assign flush = rst_i | clear_i;

  // Bundle the interface inputs into the control struct.
  always_comb begin
    ctrl.start        = sched_io.start_i;
    ctrl.n_inner      = sched_io.n_inner_i;
    ctrl.n_outer      = sched_io.n_outer_i;
    ctrl.stride_inner = sched_io.stride_inner_i;
    ctrl.stride_outer = sched_io.stride_outer_i;
    ctrl.next         = sched_io.next_i;
  end

  assign last_in  = (i_in_q == n_inner_q - cnt_t'(1));
  assign last_out = (i_out_q == n_outer_q - cnt_t'(1));

  // FSM next state, loop counters and offset-step controls.
  always_comb begin
    state_d        = state_q;
    n_inner_d      = n_inner_q;
    n_outer_d      = n_outer_q;
    i_in_d         = i_in_q;
    i_out_d        = i_out_q;
    tile_idx_d     = tile_idx_q;
    stride_inner_d = stride_inner_q;
    stride_outer_d = stride_outer_q;
    load           = 1'b0;
    inner_step     = 1'b0;
    outer_step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl.start) begin
          if (ctrl.n_inner != '0 && ctrl.n_outer != '0) begin
            n_inner_d      = ctrl.n_inner;
            n_outer_d      = ctrl.n_outer;
            stride_inner_d = ctrl.stride_inner;
            stride_outer_d = ctrl.stride_outer;
            i_in_d         = '0;
            i_out_d        = '0;
            tile_idx_d     = '0;
            load           = 1'b1;
            state_d        = StRun;
          end else begin
            // Empty job: no tile offered, just the end-of-job pulse.
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (ctrl.next) begin
          tile_idx_d = tile_idx_q + tidx_t'(1);
          if (last_in && last_out) begin
            state_d = StDone;
          end else if (last_in) begin
            i_in_d     = '0;
            i_out_d    = i_out_q + cnt_t'(1);
            outer_step = 1'b1;
          end else begin
            i_in_d     = i_in_q + cnt_t'(1);
            inner_step = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scheduler state with synchronous reset/clear.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q        <= StIdle;
      n_inner_q      <= '0;
      n_outer_q      <= '0;
      i_in_q         <= '0;
      i_out_q        <= '0;
      tile_idx_q     <= '0;
      stride_inner_q <= '0;
      stride_outer_q <= '0;
    end else begin
      state_q        <= state_d;
      n_inner_q      <= n_inner_d;
      n_outer_q      <= n_outer_d;
      i_in_q         <= i_in_d;
      i_out_q        <= i_out_d;
      tile_idx_q     <= tile_idx_d;
      stride_inner_q <= stride_inner_d;
      stride_outer_q <= stride_outer_d;
    end
  end

  for (genvar s = 0; s < NbStreams; s++) begin : g_offs
    multi_dataflow_tile_sched_offs_gen u_offs_gen (
      .clk_i          (clk_i),
      .clear_i        (flush),
      .load_i         (load),
      .inner_step_i   (inner_step),
      .outer_step_i   (outer_step),
      .stride_inner_i (stride_inner_q[s]),
      .stride_outer_i (stride_outer_q[s]),
      .offs_o         (offs[s])
    );
  end

  // Output flags decoded from the FSM state.
  always_comb begin
    flags.offs     = offs;
    flags.valid    = (state_q == StRun);
    flags.tile_idx = tile_idx_q;
    flags.busy     = (state_q != StIdle);
    flags.done     = (state_q == StDone);
  end

  assign sched_io.offs_o     = flags.offs;
  assign sched_io.valid_o    = flags.valid;
  assign sched_io.tile_idx_o = flags.tile_idx;
  assign sched_io.busy_o     = flags.busy;
  assign sched_io.done_o     = flags.done;

endmodule
